tick_sched: RTL and testbench
=============================

TICK_SCHED -- requirements
Module: tick_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DW, default 8, divisor width in bits.
REQ-003 SHALL have parameter NTICK, default 4, ticks issued per grant (1..255).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  input  NREQ  per-requester request level.
REQ-007 SHALL have port div  input  NREQ*DW  packed divisors; requester i uses bits [i*DW +: DW].
REQ-008 SHALL have port gnt  output  NREQ  one-hot grant, registered.
REQ-009 SHALL have port tick  output  1  one-cycle pulse per divided period, registered.
REQ-010 SHALL have port done  output  1  one-cycle pulse at end of a completed grant, registered.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port clk_out  output  1  toggled divided clock (see Configuration).

Function
REQ-013 SHALL implement states IDLE, LOAD, RUN, DONE.
REQ-014 IDLE: any req bit high -> LOAD next cycle; gnt set to the winner at that edge.
REQ-015 Arbitration SHALL be round-robin; search starts at pointer ptr, wraps NREQ-1 -> 0; ptr resets to 0.
REQ-016 LOAD (1 cycle): latch divisor of granted requester; value 0 SHALL be treated as 1; counter <- divisor-1, tick count <- 0; -> RUN.
REQ-017 RUN: counter decrements each cycle; at counter==0 assert tick for one cycle, reload divisor-1, increment tick count.
REQ-018 Tick spacing SHALL be exactly divisor cycles; first tick divisor cycles after LOAD.
REQ-019 After the NTICK-th tick -> DONE; DONE asserts done for one cycle, clears gnt, sets ptr to granted index+1 (mod NREQ), -> IDLE.
REQ-020 Granted req dropping during LOAD or RUN SHALL abort: next cycle gnt cleared, no done, no further tick, ptr advanced as in REQ-019, -> IDLE.
REQ-021 div changes after LOAD SHALL NOT affect the running grant.
REQ-022 Requests from non-granted requesters SHALL be ignored until IDLE; no preemption.
REQ-023 gnt SHALL never have more than one bit set; tick and done SHALL never be high in the same cycle.
REQ-024 Minimum grant-to-grant gap: one IDLE cycle between DONE and next LOAD.

Reset
REQ-025 On rst low, asynchronously: state=IDLE, gnt=0, tick=0, done=0, busy=0, clk_out=0, ptr=0, counters=0.
REQ-026 Reset asserted mid-RUN SHALL abandon the grant silently; after release operation resumes from IDLE with ptr=0.
REQ-027 Reset release SHALL take effect on the first rising clk edge after rst goes high.

Configuration
REQ-028 Macro TICK_SCHED_CLKOUT_EN: defined -> clk_out toggles on every tick, cleared to 0 on entering IDLE; undefined -> clk_out tied constant 0 and toggle register omitted.

Verification
REQ-029 Single request: req=4'b0001, div0=3, NTICK=4 -> gnt=0001 one cycle after req, ticks every 3 cycles (4 total), done 1 cycle after 4th tick, gnt=0 after.
REQ-030 Round-robin: req=4'b1111 held, all div=1 -> grant order 0,1,2,3,0 with done after each.
REQ-031 Zero divisor: div2=0, req=4'b0100 -> ticks on consecutive RUN cycles, 4 ticks, done.
REQ-032 Abort: req0 dropped after 2nd tick (div0=5) -> gnt=0 next cycle, no done, next grant goes to requester 1 if requesting.
REQ-033 Reset mid-RUN: rst low for 3 cycles during RUN -> all outputs 0 immediately; after release req=0010 gets grant starting from ptr=0 search.
REQ-034 With TICK_SCHED_CLKOUT_EN, div=2, NTICK=4 -> clk_out toggles 4 times, period 4 cycles, 0 after DONE; without macro clk_out stays 0.

Source files
------------

// File: rtl/tick_sched.sv
// tick_sched: round-robin scheduler that issues NTICK divided ticks per grant.
// Define TICK_SCHED_CLKOUT_EN to drive a toggled divided clock on clk_out.
module tick_sched #(
   parameter int NREQ  = 4,
   parameter int DW    = 8,
   parameter int NTICK = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*DW-1:0] div,
   output logic [NREQ-1:0]    gnt,
   output logic               tick,
   output logic               done,
   output logic               busy,
   output logic               clk_out
);
   localparam int IW = $clog2(NREQ);
   localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);
   localparam logic [7:0] LAST_TICK = 8'(NTICK - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

   state_t          r_state, w_next;
   logic [NREQ-1:0] r_gnt;
   logic [IW-1:0]   r_ptr, r_idx, w_win, w_ptr_next;
   logic [DW-1:0]   r_div, r_cnt, w_div_sel, w_div_eff;
   logic [7:0]      r_tcnt;
   logic            r_tick, r_done;
   logic            w_any, w_hold, w_cnt_zero, w_last, w_fire, w_busy;

   function automatic logic [IW-1:0] f_wrap(input logic [IW:0] s);
      logic [IW:0] t;
      t = (s >= NREQ_W) ? s - NREQ_W : s;
      return t[IW-1:0];
   endfunction

   // Scan from the far end toward r_ptr so the nearest requester is assigned last and wins.
   always_comb begin
      w_win = r_ptr;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[f_wrap({1'b0, r_ptr} + (IW+1)'(k))]) w_win = f_wrap({1'b0, r_ptr} + (IW+1)'(k));
      end
   end

   // NOTE: every combinational output gets a default before any branch so no latch is inferred.
   always_comb begin
      w_div_sel = '0;
      w_hold    = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (r_idx == IW'(i)) begin
            w_div_sel = div[i*DW +: DW];
            w_hold    = req[i];
         end
      end
   end

   assign w_any      = |req;
   assign w_div_eff  = (w_div_sel == '0) ? DW'(1) : w_div_sel;
   assign w_ptr_next = f_wrap({1'b0, r_idx} + (IW+1)'(1));
   assign w_cnt_zero = (r_cnt == '0);
   assign w_last     = (r_tcnt == LAST_TICK);
   assign w_fire     = (r_state == S_RUN) && w_hold && w_cnt_zero;

   // NOTE: state is updated with non-blocking assignments and cleared asynchronously on rst low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_any) w_next = S_LOAD;
         S_LOAD:  w_next = w_hold ? S_RUN : S_IDLE;
         S_RUN:   if (!w_hold) w_next = S_IDLE;
                  else if (w_cnt_zero && w_last) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_busy = (r_state != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_gnt  <= '0;
         r_ptr  <= '0;
         r_idx  <= '0;
         r_div  <= '0;
         r_cnt  <= '0;
         r_tcnt <= '0;
         r_tick <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_tick <= 1'b0;
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_gnt <= NREQ'(1) << w_win;
                  r_idx <= w_win;
               end
            end
            S_LOAD, S_RUN: begin
               // Losing the granted request aborts silently: no tick, no done.
               if (!w_hold) begin
                  r_gnt <= '0;
                  r_ptr <= w_ptr_next;
               end else if (r_state == S_LOAD) begin
                  r_div  <= w_div_eff;
                  r_cnt  <= w_div_eff - DW'(1);
                  r_tcnt <= '0;
               end else if (w_cnt_zero) begin
                  r_tick <= 1'b1;
                  r_cnt  <= r_div - DW'(1);
                  r_tcnt <= r_tcnt + 8'd1;
               end else begin
                  r_cnt <= r_cnt - DW'(1);
               end
            end
            S_DONE: begin
               r_done <= 1'b1;
               r_gnt  <= '0;
               r_ptr  <= w_ptr_next;
            end
            default: ;
         endcase
      end
   end

`ifdef TICK_SCHED_CLKOUT_EN
   logic r_clk_out;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                  r_clk_out <= 1'b0;
      else if (w_next == S_IDLE) r_clk_out <= 1'b0;
      else if (w_fire)           r_clk_out <= ~r_clk_out;
   end

   assign clk_out = r_clk_out;
`else
   assign clk_out = 1'b0;
`endif

   assign gnt  = r_gnt;
   assign tick = r_tick;
   assign done = r_done;
   assign busy = w_busy;
endmodule

// File: tb/tb_tick_sched.sv
// Bench for tick_sched: grant-age arithmetic model checked every cycle, plus directed literal scenarios.
module tb_tick_sched;
   localparam int NREQ  = 4;
   localparam int DW    = 8;
   localparam int NTICK = 4;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [NREQ-1:0]    req = '0;
   logic [NREQ*DW-1:0] div = '0;
   logic [NREQ-1:0]    gnt;
   logic               tick, done, busy, clk_out;

   tick_sched #(.NREQ(NREQ), .DW(DW), .NTICK(NTICK)) dut (
      .clk(clk), .rst(rst), .req(req), .div(div),
      .gnt(gnt), .tick(tick), .done(done), .busy(busy), .clk_out(clk_out)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Model: a grant is described by its LOAD cycle and divisor; outputs follow from the grant's age.
   int cyc = 0, m_start = 0, m_idx = 0, m_d = 1, m_ptr = 0;
   bit m_active = 1'b0, m_done = 1'b0;

   function automatic int eff_div(input int i);
      logic [DW-1:0] v;
      v = div[i*DW +: DW];
      return (v == '0) ? 1 : int'(v);
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_active = 1'b0; m_done = 1'b0; m_ptr = 0; cyc = 0;
      end else begin
         int p, ap, j;
         bit found;
         p = cyc;
         m_done = 1'b0;
         if (m_active) begin
            ap = p - m_start;
            if (ap == 0 || ap <= m_d * NTICK) begin
               if (!req[m_idx]) begin
                  m_active = 1'b0;
                  m_ptr = (m_idx + 1) % NREQ;
               end else if (ap == 0) begin
                  m_d = eff_div(m_idx);
               end
            end else begin
               m_active = 1'b0;
               m_done = 1'b1;
               m_ptr = (m_idx + 1) % NREQ;
            end
         end else if (req != '0) begin
            found = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
               j = (m_ptr + k) % NREQ;
               if (!found && req[j]) begin
                  found = 1'b1;
                  m_idx = j;
               end
            end
            m_active = 1'b1;
            m_start = p + 1;
         end
         cyc = p + 1;
      end
   end

   logic [NREQ-1:0] e_gnt;
   logic            e_tick, e_done, e_busy, e_clk;
   int              e_age;

   always @(negedge clk) begin
      if (rst) begin
         e_gnt = '0; e_tick = 1'b0; e_done = m_done; e_busy = 1'b0; e_clk = 1'b0;
         if (m_active) begin
            e_age = cyc - m_start;
            e_gnt = NREQ'(1) << m_idx;
            e_busy = 1'b1;
            e_done = 1'b0;
            if (e_age >= 1) begin
               e_tick = (e_age - 1 > 0) && ((e_age - 1) % m_d == 0);
`ifdef TICK_SCHED_CLKOUT_EN
               e_clk = (((e_age - 1) / m_d) % 2) == 1;
`endif
            end
         end
         check($sformatf("outputs@%0d", cyc), {24'd0, gnt, tick, done, busy, clk_out},
               {24'd0, e_gnt, e_tick, e_done, e_busy, e_clk});
         check("onehot_gnt_tick_done_exclusive", {31'd0, $onehot0(gnt) && !(tick && done)}, 32'd1);
      end
   end

   logic [NREQ-1:0] cap_gnt [0:31];
   logic [31:0]     cap_tick, cap_done, cap_clk;

   task automatic run_capture(input int ncyc, input int drop_at, input logic [NREQ-1:0] drop_req);
      cap_tick = '0; cap_done = '0; cap_clk = '0;
      for (int c = 1; c <= ncyc; c++) begin
         @(posedge clk);
         @(negedge clk);
         cap_gnt[c]  = gnt;
         cap_tick[c] = tick;
         cap_done[c] = done;
         cap_clk[c]  = clk_out;
         if (c == drop_at) req = drop_req;
      end
   endtask

   task automatic do_reset(input string tag, input logic [NREQ-1:0] rel_req);
      @(posedge clk);
      #2 rst = 1'b0;
      #1 check({tag, "_async_reset_outputs"}, {24'd0, gnt, tick, done, busy, clk_out}, 32'd0);
      repeat (3) @(negedge clk);
      req = rel_req;
      rst = 1'b1;
   endtask

   function automatic int idx_of(input logic [NREQ-1:0] g);
      for (int i = 0; i < NREQ; i++) if (g[i]) return i;
      return -1;
   endfunction

   int              rr_got, rr_done;
   int              rr_order [5];
   int              rr_exp [5] = '{0, 1, 2, 3, 0};
   logic [NREQ-1:0] rr_prev;

   initial begin
      #1 rst = 1'b0;
      #1 check("power_on_reset_outputs", {24'd0, gnt, tick, done, busy, clk_out}, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Single request, divisor 3: LOAD at cycle 1, ticks every 3 cycles, done after the 4th.
      do_reset("single", '0);
      div = '0;
      div[0 +: DW] = DW'(3);
      req = 4'b0001;
      run_capture(16, 14, 4'b0000);
      check("single_gnt_first_cycle", {28'd0, cap_gnt[1]}, 32'h1);
      check("single_tick_cycles", cap_tick, 32'h0000_4920);
      check("single_done_cycle", cap_done, 32'h0000_8000);
      check("single_gnt_in_done_state", {28'd0, cap_gnt[14]}, 32'h1);
      check("single_gnt_after_done", {28'd0, cap_gnt[15]}, 32'h0);

      // Zero divisor behaves as 1: ticks on consecutive RUN cycles.
      do_reset("zero_div", '0);
      div = {DW'(1), DW'(0), DW'(1), DW'(1)};
      req = 4'b0100;
      run_capture(10, 6, 4'b0000);
      check("zero_div_gnt", {28'd0, cap_gnt[1]}, 32'h4);
      check("zero_div_tick_cycles", cap_tick, 32'h0000_0078);
      check("zero_div_done_cycle", cap_done, 32'h0000_0080);

      // Round-robin with every requester active and divisor 1.
      do_reset("rr", '0);
      div = {DW'(1), DW'(1), DW'(1), DW'(1)};
      req = 4'b1111;
      rr_got = 0; rr_done = 0; rr_prev = '0;
      for (int i = 0; i < 5; i++) rr_order[i] = -1;
      for (int c = 0; c < 200 && rr_got < 5; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) rr_done++;
         if (gnt != '0 && rr_prev == '0) begin
            rr_order[rr_got] = idx_of(gnt);
            rr_got++;
         end
         rr_prev = gnt;
      end
      check("rr_grants_seen", rr_got, 5);
      for (int i = 0; i < 5; i++) check($sformatf("rr_order_%0d", i), rr_order[i], rr_exp[i]);
      check("rr_dones_before_fifth", rr_done, 4);
      req = '0;
      repeat (4) @(negedge clk);

      // Abort: requester 0 drops right after its 2nd tick; requester 1 is next.
      do_reset("abort", '0);
      div = {DW'(1), DW'(1), DW'(2), DW'(5)};
      req = 4'b0011;
      run_capture(16, 12, 4'b0010);
      check("abort_tick_cycles", cap_tick, 32'h0000_1080);
      check("abort_no_done", cap_done, 32'h0);
      check("abort_gnt_cleared", {28'd0, cap_gnt[13]}, 32'h0);
      check("abort_next_grant", {28'd0, cap_gnt[14]}, 32'h2);
      req = '0;
      repeat (4) @(negedge clk);

      // Reset in the middle of a RUN restarts arbitration from pointer 0.
      do_reset("midrun_pre", '0);
      div = {DW'(1), DW'(1), DW'(3), DW'(1)};
      req = 4'b0001;
      run_capture(11, 6, 4'b0010);
      check("midrun_running_gnt", {28'd0, cap_gnt[11]}, 32'h2);
      do_reset("midrun", 4'b0011);
      run_capture(2, 0, 4'b0000);
      check("midrun_regrant_from_ptr0", {28'd0, cap_gnt[1]}, 32'h1);
      req = '0;
      repeat (4) @(negedge clk);

      // Divided clock output, divisor 2.
      do_reset("clkout", '0);
      div = {DW'(2), DW'(1), DW'(1), DW'(1)};
      req = 4'b1000;
      run_capture(12, 10, 4'b0000);
      check("clkout_tick_cycles", cap_tick, 32'h0000_0550);
      check("clkout_done_cycle", cap_done, 32'h0000_0800);
`ifdef TICK_SCHED_CLKOUT_EN
      check("clkout_waveform", cap_clk, 32'h0000_0330);
`else
      check("clkout_waveform", cap_clk, 32'h0);
`endif

      // Randomised traffic: requests rise and fall, divisors change while grants run.
      do_reset("random", '0);
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         for (int i = 0; i < NREQ; i++) begin
            if (!req[i]) begin
               if ($urandom_range(0, 7) == 0) req[i] = 1'b1;
            end else if ($urandom_range(0, 39) == 0) begin
               req[i] = 1'b0;
            end
            if ($urandom_range(0, 15) == 0) div[i*DW +: DW] = DW'($urandom_range(0, 4));
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
endmodule
